// File: rtl/fir_pkg.sv
// Shared FIR datapath constants and width helpers.
// Imported by checksum_top and fir_tap_accumulator.
package fir_pkg;

  localparam int IN_DATA_WIDTH  = 17;
  localparam int POLY_WIDTH     = 17;
  localparam int SUM_WIDTH      = 34;
  localparam int OUT_DATA_WIDTH = 21;
  localparam int NUM_TAPS       = 16;
  localparam int SHIFT          = 16;

  // ceil(log2(v)); v is at least 2 wherever this is used
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // accumulator wide enough that n products of sw bits never overflow
  function automatic int acc_width(input int sw, input int n);
    return sw + clog2(n);
  endfunction

  localparam int ACC_WIDTH = acc_width(SUM_WIDTH, NUM_TAPS);

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up, arithmetic shift and clip of a wide signed sum.
// Purely combinational; sits between res_reg and the output register.
module fir_round_sat #(
  parameter int IN_W  = 38,
  parameter int SHIFT = 16,
  parameter int OUT_W = 21
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);

  localparam logic signed [IN_W:0] RND  =
    (IN_W+1)'(64'sd1 << (SHIFT-1));
  localparam logic signed [IN_W:0] MAXV =
    (IN_W+1)'((64'sd1 << (OUT_W-1)) - 64'sd1);
  localparam logic signed [IN_W:0] MINV = ~MAXV;

  logic signed [IN_W:0] ext;
  logic signed [IN_W:0] sum_rnd;
  logic signed [IN_W:0] shr;

  // one extra bit so the rounding add cannot wrap
  always_comb begin
    ext     = {din[IN_W-1], din};
    sum_rnd = ext + RND;
    shr     = sum_rnd >>> SHIFT;
    dout    = shr[OUT_W-1:0];
    sat     = 1'b0;
    if (shr > MAXV) begin
      dout = MAXV[OUT_W-1:0];
      sat  = 1'b1;
    end else if (shr < MINV) begin
      dout = MINV[OUT_W-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/fir_tap_accumulator.sv
// Sums NUM_TAPS consecutive products into one FIR sample,
// then rounds/saturates it into a one-cycle output pulse.
module fir_tap_accumulator #(
  parameter int SUM_WIDTH      = fir_pkg::SUM_WIDTH,
  parameter int OUT_DATA_WIDTH = fir_pkg::OUT_DATA_WIDTH,
  parameter int NUM_TAPS       = fir_pkg::NUM_TAPS,
  parameter int SHIFT          = fir_pkg::SHIFT,
  parameter int ACC_WIDTH      =
    fir_pkg::acc_width(SUM_WIDTH, NUM_TAPS),
  parameter int CNT_W          = fir_pkg::clog2(NUM_TAPS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_data_vld,
  input  logic signed [SUM_WIDTH-1:0]      in_data,
  input  logic                             sync_clr,
  output logic signed [OUT_DATA_WIDTH-1:0] out_data,
  output logic                             out_data_vld,
  output logic                             sat_flag,
  output logic [CNT_W-1:0]                 tap_cnt
);

  import fir_pkg::*;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TAPS - 1);

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] res_q, res_d;
  logic signed [ACC_WIDTH-1:0] in_ext;
  logic signed [ACC_WIDTH-1:0] sum_c;
  logic [CNT_W-1:0]            tap_cnt_q, tap_cnt_d;
  logic                        res_vld_q, res_vld_d;

  logic signed [OUT_DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                             out_vld_q, out_vld_d;
  logic                             sat_q, sat_d;

  logic signed [OUT_DATA_WIDTH-1:0] rs_dout;
  logic                             rs_sat;

  // stage 1: accumulate; frame end loads res and clears acc together
  always_comb begin
    in_ext = {{(ACC_WIDTH-SUM_WIDTH){in_data[SUM_WIDTH-1]}},
              in_data};
    sum_c     = acc_q + in_ext;
    acc_d     = acc_q;
    tap_cnt_d = tap_cnt_q;
    res_d     = res_q;
    res_vld_d = 1'b0;
    if (sync_clr) begin
      acc_d     = '0;
      tap_cnt_d = '0;
    end else if (in_data_vld) begin
      if (tap_cnt_q == LAST) begin
        res_d     = sum_c;
        res_vld_d = 1'b1;
        acc_d     = '0;
        tap_cnt_d = '0;
      end else begin
        acc_d     = sum_c;
        tap_cnt_d = tap_cnt_q + 1'b1;
      end
    end
  end

  fir_round_sat #(
    .IN_W  (ACC_WIDTH),
    .SHIFT (SHIFT),
    .OUT_W (OUT_DATA_WIDTH)
  ) u_round_sat (
    .din  (res_q),
    .dout (rs_dout),
    .sat  (rs_sat)
  );

  // stage 2: register rounded result; data holds between pulses
  always_comb begin
    out_vld_d  = res_vld_q;
    out_data_d = res_vld_q ? rs_dout : out_data_q;
    sat_d      = res_vld_q & rs_sat;
  end

  // state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q      <= '0;
      tap_cnt_q  <= '0;
      res_q      <= '0;
      res_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      tap_cnt_q  <= tap_cnt_d;
      res_q      <= res_d;
      res_vld_q  <= res_vld_d;
      out_data_q <= out_data_d;
      out_vld_q  <= out_vld_d;
      sat_q      <= sat_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_data_vld = out_vld_q;
  assign sat_flag     = sat_q;
  assign tap_cnt      = tap_cnt_q;

endmodule

// File: tb/tb_fir_tap_accumulator.sv
// Self-checking bench for fir_tap_accumulator.
// Frame-level reference model driven by directed and random stimulus.
module tb_fir_tap_accumulator;

  localparam int NT   = 16;
  localparam int SH   = 16;
  localparam int OW   = 21;
  localparam int SW   = 34;

  logic                 clk;
  logic                 reset;
  logic                 in_data_vld;
  logic signed [SW-1:0] in_data;
  logic                 sync_clr;
  logic signed [OW-1:0] out_data;
  logic                 out_data_vld;
  logic                 sat_flag;
  logic [3:0]           tap_cnt;

  int n_chk;
  int n_fail;

  // reference model state
  longint q[$];
  bit     pend_vld;
  longint pend_data;
  bit     pend_sat;
  bit     e_vld;
  longint e_data;
  bit     e_sat;

  fir_tap_accumulator dut (
    .clk          (clk),
    .reset        (reset),
    .in_data_vld  (in_data_vld),
    .in_data      (in_data),
    .sync_clr     (sync_clr),
    .out_data     (out_data),
    .out_data_vld (out_data_vld),
    .sat_flag     (sat_flag),
    .tap_cnt      (tap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void ref_out(input longint s,
                                  output longint o,
                                  output bit st);
    longint r;
    longint mx;
    longint mn;
    mx = (longint'(1) <<< (OW-1)) - 1;
    mn = -(longint'(1) <<< (OW-1));
    r  = (s + (longint'(1) <<< (SH-1))) >>> SH;
    st = 1'b0;
    o  = r;
    if (r > mx) begin
      o  = mx;
      st = 1'b1;
    end else if (r < mn) begin
      o  = mn;
      st = 1'b1;
    end
  endfunction

  function automatic void model_clear();
    q.delete();
    pend_vld  = 1'b0;
    pend_data = 0;
    pend_sat  = 1'b0;
    e_vld     = 1'b0;
    e_data    = 0;
    e_sat     = 1'b0;
  endfunction

  // one clock: drive at negedge, model the edge, check next negedge
  task automatic cyc(input bit v, input longint d, input bit c);
    longint s;
    in_data_vld = v;
    in_data     = SW'(d);
    sync_clr    = c;
    @(posedge clk);
    e_vld = pend_vld;
    e_sat = 1'b0;
    if (pend_vld) begin
      e_data = pend_data;
      e_sat  = pend_sat;
    end
    pend_vld = 1'b0;
    if (c) begin
      q.delete();
    end else if (v) begin
      q.push_back(d);
      if (q.size() == NT) begin
        s = 0;
        foreach (q[i]) s += q[i];
        ref_out(s, pend_data, pend_sat);
        pend_vld = 1'b1;
        q.delete();
      end
    end
    @(negedge clk);
    chk("vld", longint'(out_data_vld), longint'(e_vld));
    chk("tap_cnt", longint'(tap_cnt), longint'(q.size()));
    chk("data", longint'(out_data), e_data);
    chk("sat", longint'(sat_flag), longint'(e_sat));
  endtask

  task automatic frame(input longint d, input bit gap);
    for (int i = 0; i < NT; i++) begin
      cyc(1'b1, d, 1'b0);
      if (gap) cyc(1'b0, 0, 1'b0);
    end
  endtask

  task automatic frame_last(input longint z, input longint d);
    for (int i = 0; i < NT-1; i++) cyc(1'b1, z, 1'b0);
    cyc(1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0);
  endtask

  initial begin
    logic signed [SW-1:0] rd;
    n_chk       = 0;
    n_fail      = 0;
    reset       = 1'b1;
    in_data_vld = 1'b0;
    in_data     = '0;
    sync_clr    = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_vld", longint'(out_data_vld), 0);
    chk("rst_data", longint'(out_data), 0);
    chk("rst_sat", longint'(sat_flag), 0);
    chk("rst_cnt", longint'(tap_cnt), 0);
    reset = 1'b0;

    // unity sum
    frame(65536, 1'b0);
    idle(3);
    // rounding boundaries
    frame_last(0, 32768);
    idle(2);
    frame_last(0, -32768);
    idle(2);
    frame_last(0, -32769);
    idle(2);
    // saturation both ways
    frame((longint'(1) <<< 33) - 1, 1'b0);
    idle(2);
    frame(-(longint'(1) <<< 33), 1'b0);
    idle(2);
    // gapped, then back-to-back frames
    frame(65536, 1'b1);
    frame(65536, 1'b0);
    frame(131072, 1'b0);
    idle(2);
    // sync_clr with a valid product dropped
    for (int i = 0; i < 5; i++) cyc(1'b1, 65536, 1'b0);
    cyc(1'b1, 65536, 1'b1);
    frame(65536, 1'b0);
    // sync_clr right after a frame's last product
    frame(196608, 1'b0);
    cyc(1'b0, 0, 1'b1);
    idle(2);

    // async reset mid-frame, mid-cycle
    for (int i = 0; i < 10; i++) cyc(1'b1, 65536, 1'b0);
    in_data_vld = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("mrst_vld", longint'(out_data_vld), 0);
    chk("mrst_data", longint'(out_data), 0);
    chk("mrst_sat", longint'(sat_flag), 0);
    chk("mrst_cnt", longint'(tap_cnt), 0);
    #1 reset = 1'b0;
    model_clear();
    @(negedge clk);
    frame(65536, 1'b0);
    idle(2);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rd = SW'({$urandom(), $urandom()});
      case ($urandom_range(0, 3))
        0: rd = SW'($signed($urandom_range(0, 262143)) - 131072);
        1: rd = rd >>> 8;
        default: ;
      endcase
      cyc($urandom_range(0, 3) != 0, longint'(rd),
          $urandom_range(0, 40) == 0);
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
